// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, op codes and sequencer states.
package alu_pkg;

    localparam int unsigned W   = 4;
    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_ADD = 2'd0;
    localparam logic [OPW-1:0] OP_SUB = 2'd1;
    localparam logic [OPW-1:0] OP_AND = 2'd2;
    localparam logic [OPW-1:0] OP_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, contention goes to rr_ptr_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_id_o = 1'b0;
        unique case (req_i)
            2'b01: begin
                gnt_o    = 2'b01;
                gnt_id_o = 1'b0;
            end
            2'b10: begin
                gnt_o    = 2'b10;
                gnt_id_o = 1'b1;
            end
            2'b11: begin
                gnt_o    = rr_ptr_i ? 2'b10 : 2'b01;
                gnt_id_o = rr_ptr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters: accept, execute one
// cycle, then hold the response until the granted requester takes it.
module alu_share_arb #(
    parameter int unsigned W   = 4,
    parameter int unsigned OPW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*OPW-1:0] req_op,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_res,
    output logic             rsp_cout,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [W-1:0]     alu_res,
    input  logic             alu_cout,
    output logic             busy,
    output logic             grant_id
);

    import alu_pkg::*;

    state_e         state_q;
    logic           rr_ptr_q;
    logic           grant_id_q;
    logic [1:0]     rsp_valid_q;
    logic [W-1:0]   rsp_res_q;
    logic           rsp_cout_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [OPW-1:0] alu_op_q;

    logic [1:0]     gnt;
    logic           gnt_id;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    rr_arb2 u_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req_ready = (state_q == IDLE) ? gnt : 2'b00;

    assign sel_op = gnt_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
    assign sel_a  = gnt_id ? req_a[2*W-1:W]      : req_a[W-1:0];
    assign sel_b  = gnt_id ? req_b[2*W-1:W]      : req_b[W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            grant_id_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_res_q   <= '0;
            rsp_cout_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_ready) begin
                        alu_a_q    <= sel_a;
                        alu_b_q    <= sel_b;
                        alu_op_q   <= sel_op;
                        grant_id_q <= gnt_id;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res_q   <= alu_res;
                    rsp_cout_q  <= alu_cout;
                    rsp_valid_q <= grant_id_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Pointer moves only on completion so a lone requester can repeat.
                    if (rsp_ready[grant_id_q]) begin
                        rsp_valid_q <= 2'b00;
                        rr_ptr_q    <= ~grant_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cout  = rsp_cout_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;

endmodule
